axi_delay_gate: RTL and testbench

Parametrised AXI4 delay injector between an AXI master and a slave RAM/peripheral model, used to stress cores with variable memory latency. Each of the five channels (AW, W, B, AR, R) has its own gate with an independent LFSR, a configurable stall probability and a minimum per-beat delay. Gates hold a forwarded VALID until its handshake completes, so the injector never violates AXI VALID-stability rules. A runtime bypass mode and a stall-cycle counter are included.

---
 rtl/axi_delay_gate.sv | 189 ++++++++++++++++++
 tb/tb_axi_delay_gate.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_delay_gate.sv
// AXI4 latency injector: one valid/ready gate per channel, each stalling beats with its own LFSR
// and a minimum WAIT time. Payloads pass straight through; bypass changes apply only when all channels are quiet.
module axi_delay_gate #(
  parameter int             ID_W      = 4,
  parameter int             ADDR_W    = 32,
  parameter int             DATA_W    = 32,
  parameter int             MIN_DELAY = 0,
  parameter logic [7:0]     STALL_THR = 8'd64,
  parameter logic [15:0]    SEED      = 16'hACE1
) (
  input  logic                s_aclk,
  input  logic                s_aresetn,
  input  logic                delay_en,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [31:0]         stall_cycles
);

  localparam int         NCH   = 5;
  localparam logic [7:0] MIN_D = 8'(MIN_DELAY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_OPEN} gate_state_e;

  logic [NCH-1:0] vi, ri, vo, ro, idle_vec, wait_vec;
  logic           mode_q;

  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bresp   = m_axi_bresp;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast;

  // Channel index order: AW, W, B, AR, R (B and R flow slave -> master).
  assign vi = {m_axi_rvalid, s_axi_arvalid, m_axi_bvalid, s_axi_wvalid, s_axi_awvalid};
  assign ri = {s_axi_rready, m_axi_arready, s_axi_bready, m_axi_wready, m_axi_awready};

  assign m_axi_awvalid = vo[0];
  assign s_axi_awready = ro[0];
  assign m_axi_wvalid  = vo[1];
  assign s_axi_wready  = ro[1];
  assign s_axi_bvalid  = vo[2];
  assign m_axi_bready  = ro[2];
  assign m_axi_arvalid = vo[3];
  assign s_axi_arready = ro[3];
  assign s_axi_rvalid  = vo[4];
  assign m_axi_rready  = ro[4];

  for (genvar k = 0; k < NCH; k++) begin : g_gate
    localparam logic [15:0] SEED_RAW = SEED ^ (16'h1111 * 16'(k));
    localparam logic [15:0] SEED_K   = (SEED_RAW == 16'h0000) ? 16'hACE1 : SEED_RAW;

    gate_state_e state_q, state_d;
    logic [7:0]  cnt_q;
    logic [15:0] lfsr_q;
    logic        pass, vo_k, ro_k;

    assign pass = lfsr_q[7:0] >= STALL_THR;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        lfsr_q  <= SEED_K;
      end else begin
        state_q <= state_d;
        lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        if (state_q == ST_WAIT) cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        else                    cnt_q <= '0;
      end
    end

    // OPEN is sticky so a forwarded VALID is never withdrawn before its handshake.
    always_comb begin
      state_d = state_q;
      if (!mode_q) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (vi[k]) state_d = ST_WAIT;
          ST_WAIT: begin
            if (!vi[k])                     state_d = ST_IDLE;
            else if (cnt_q >= MIN_D && pass) state_d = ST_OPEN;
          end
          ST_OPEN: if (!vi[k] || ri[k]) state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_comb begin
      vo_k = 1'b0;
      ro_k = 1'b0;
      if (!mode_q) begin
        vo_k = vi[k];
        ro_k = ri[k];
      end else if (state_q == ST_OPEN) begin
        vo_k = vi[k];
        ro_k = ri[k];
      end
    end

    assign vo[k]       = vo_k;
    assign ro[k]       = ro_k;
    assign idle_vec[k] = (state_q == ST_IDLE);
    assign wait_vec[k] = (state_q == ST_WAIT);
  end

  // Mode only changes when no beat is in flight on any channel.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      mode_q       <= 1'b1;
      stall_cycles <= '0;
    end else begin
      if (&idle_vec && vi == '0) mode_q <= delay_en;
      if (|wait_vec && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_delay_gate.sv
// Directed/randomized bench for axi_delay_gate; beat timing is predicted from cycle index
// since reset and the per-channel LFSR sequence, independent of any gate state machine.
module tb_axi_delay_gate;

  localparam int          MIN  = 3;
  localparam logic [7:0]  THR  = 8'd96;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        delay_en = 1'b1;
  logic [4:0]  vi = '0, ri = '0;
  logic [4:0]  vo, ro;
  int          cyc;
  int          checks = 0, errors = 0;
  int          stall_exp = 0;
  int          w_hs = 0;
  logic [31:0] cap_wdata, cap_rdata;
  logic        cap_wlast;
  logic [3:0]  cap_bid;

  logic [3:0]  s_axi_awid = '0, s_axi_arid = '0, m_axi_bid = '0, m_axi_rid = '0;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0, m_axi_rdata = '0;
  logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'd1, s_axi_arburst = 2'd1, m_axi_bresp = '0, m_axi_rresp = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_wlast = 1'b0, m_axi_rlast = 1'b0;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, m_axi_bvalid, m_axi_rvalid;
  logic        m_axi_awready, m_axi_wready, m_axi_arready, s_axi_bready, s_axi_rready;
  logic        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
  logic [3:0]  m_axi_awid, m_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, s_axi_rdata, stall_cycles;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, s_axi_rlast;

  assign {m_axi_rvalid, s_axi_arvalid, m_axi_bvalid, s_axi_wvalid, s_axi_awvalid} = vi;
  assign {s_axi_rready, m_axi_arready, s_axi_bready, m_axi_wready, m_axi_awready} = ri;
  assign vo = {s_axi_rvalid, m_axi_arvalid, s_axi_bvalid, m_axi_wvalid, m_axi_awvalid};
  assign ro = {m_axi_rready, s_axi_arready, m_axi_bready, s_axi_wready, s_axi_awready};

  axi_delay_gate #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MIN_DELAY(MIN),
                   .STALL_THR(THR), .SEED(SEED)) dut (
    .s_aclk(clk), .s_aresetn(rst_n), .delay_en(delay_en),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // LFSR value of channel k during the n-th cycle after reset release.
  function automatic logic [15:0] lfsr_at(input int k, input int n);
    logic [15:0] s;
    s = SEED ^ 16'(32'h1111 * k);
    if (s == 16'h0000) s = 16'hACE1;
    for (int i = 0; i < n; i++) s = lfsr_step(s);
    return s;
  endfunction

  // First cycle a beat presented from IDLE at cycle t is forwarded: minimum wait, then the
  // first cycle whose preceding cycle's LFSR sample passes the threshold.
  function automatic int pred_open(input int k, input int t);
    int c;
    logic [15:0] s;
    c = t + 2 + MIN;
    s = lfsr_at(k, c - 1);
    while (s[7:0] < THR) begin
      s = lfsr_step(s);
      c++;
    end
    return c;
  endfunction

  // One gated beat on channel k; the sink holds ready low for rdly cycles after the beat opens.
  task automatic run_beat(input int k, input int rdly, input bit keep);
    int  t, exp_c, c;
    bit  hs, obs_hs;
    t = cyc;
    vi[k] = 1'b1;
    exp_c = pred_open(k, t);
    hs = 0;
    obs_hs = 0;
    while (!hs && cyc < t + 400) begin
      c = cyc;
      if (c < exp_c) ri[k] = 1'($urandom_range(0, 1));
      else           ri[k] = (c >= exp_c + rdly);
      @(negedge clk);
      chk($sformatf("vo ch%0d cyc%0d", k, c), 32'(vo[k]), 32'(c >= exp_c));
      chk($sformatf("ro ch%0d cyc%0d", k, c), 32'(ro[k]), 32'((c >= exp_c) && ri[k]));
      if (vo[k] && ro[k]) begin
        obs_hs = 1;
        if (k == 1) begin
          w_hs++;
          cap_wdata = m_axi_wdata;
          cap_wlast = m_axi_wlast;
        end
        if (k == 2) cap_bid = s_axi_bid;
        if (k == 4) cap_rdata = s_axi_rdata;
      end
      hs = (c >= exp_c + rdly);
      tick();
    end
    chk($sformatf("handshake ch%0d", k), 32'(obs_hs), 32'd1);
    if (!keep) vi[k] = 1'b0;
    ri[k] = 1'b0;
    stall_exp += exp_c - t - 1;
    chk($sformatf("stall_cycles ch%0d", k), stall_cycles, 32'(stall_exp));
  endtask

  initial begin
    int exp_c, t, k, n;
    logic [31:0] rd;

    // reset: all forwarded valid/ready low, payload still passes
    delay_en     = 1'b0;
    s_axi_araddr = 32'h100;
    vi = 5'h1F;
    ri = 5'h1F;
    #12;
    chk("reset vo", 32'(vo), 32'h0);
    chk("reset ro", 32'(ro), 32'h0);
    chk("reset stall", stall_cycles, 32'h0);
    chk("reset araddr pass", m_axi_araddr, 32'h100);
    vi = '0;
    ri = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // bypass: same-cycle mirror
    vi[3] = 1'b1;
    ri[3] = 1'b1;
    #1;
    chk("bypass arvalid", 32'(m_axi_arvalid), 32'd1);
    chk("bypass arready", 32'(s_axi_arready), 32'd1);
    chk("bypass araddr", m_axi_araddr, 32'h100);
    tick();
    for (int i = 0; i < 20; i++) begin
      vi = 5'($urandom_range(0, 31));
      ri = 5'($urandom_range(0, 31));
      #1;
      chk("bypass vo", 32'(vo), 32'(vi));
      chk("bypass ro", 32'(ro), 32'(ri));
      tick();
    end
    chk("bypass stall", stall_cycles, 32'h0);

    vi = '0;
    ri = '0;
    delay_en = 1'b1;
    tick();
    tick();

    // gated beats, including long sticky hold and back-to-back
    run_beat(3, 0, 0);
    run_beat(0, 20, 0);
    tick();
    run_beat(2, 2, 1);
    run_beat(2, 0, 0);
    tick();

    // 4-beat write burst then B response
    s_axi_awlen = 8'd3;
    run_beat(0, $urandom_range(0, 3), 0);
    w_hs = 0;
    for (int i = 0; i < 4; i++) begin
      s_axi_wdata = 32'h11 * (i + 1);
      s_axi_wlast = (i == 3);
      run_beat(1, $urandom_range(0, 3), i < 3);
      chk($sformatf("burst wdata %0d", i), cap_wdata, 32'h11 * (i + 1));
      chk($sformatf("burst wlast %0d", i), 32'(cap_wlast), 32'(i == 3));
    end
    chk("burst w handshakes", 32'(w_hs), 32'd4);
    s_axi_wlast = 1'b0;
    m_axi_bid = 4'h5;
    run_beat(2, 1, 0);
    chk("b id", 32'(cap_bid), 32'h5);

    // deferred mode change while R is in flight
    delay_en = 1'b0;
    m_axi_rdata = 32'hCAFE_0123;
    run_beat(4, 2, 0);
    chk("r data", cap_rdata, 32'hCAFE_0123);
    tick();
    vi[0] = 1'b1;
    #1;
    chk("bypass after deferral", 32'(m_axi_awvalid), 32'd1);
    tick();
    vi[0] = 1'b0;
    delay_en = 1'b1;
    tick();
    tick();

    // randomized beats
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 4);
      n = $urandom_range(1, 3);
      rd = $urandom;
      s_axi_wdata = rd;
      m_axi_rdata = rd;
      for (int j = 0; j < n; j++) run_beat(k, $urandom_range(0, 4), j < n - 1);
      if (k == 1) chk("rand wdata", cap_wdata, rd);
      if (k == 4) chk("rand rdata", cap_rdata, rd);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
    end

    // reset while W is open
    t = cyc;
    vi[1] = 1'b1;
    ri[1] = 1'b0;
    exp_c = pred_open(1, t);
    while (cyc < exp_c && cyc < t + 400) tick();
    chk("w open before reset", 32'(m_axi_wvalid), 32'd1);
    @(negedge clk);
    vi = 5'h1F;
    ri = 5'h1F;
    rst_n = 1'b0;
    #1;
    chk("midreset vo", 32'(vo), 32'h0);
    chk("midreset ro", 32'(ro), 32'h0);
    chk("midreset stall", stall_cycles, 32'h0);
    vi = '0;
    ri = '0;
    stall_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_beat(0, 1, 0);
    s_axi_wdata = 32'h5A5A_A5A5;
    run_beat(1, 0, 0);
    chk("post-reset wdata", cap_wdata, 32'h5A5A_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
